cla_add_sequencer: RTL
======================

CLA_ADD_SEQUENCER -- requirements
Module: cla_add_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have derived constant: NIB, WIDTH/4, number of 4-bit slice passes per operation.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  operand request.
REQ-006 SHALL have port: in_ready  output  1  sequencer can accept operands.
REQ-007 SHALL have ports: a, b  input  WIDTH  addends; cin  input  1  carry-in.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: sum  output  WIDTH  result; cout  output  1  final carry-out.
REQ-011 SHALL have port, only when CLA_SEQ_OVF_EN is defined: ovf  output  1  two's-complement overflow.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin by reusing one 4-bit carry-lookahead slice NIB times, least-significant nibble first.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE: in_ready=1; in_valid=1 captures a, b and cin into registers, sets the nibble counter to 0, and moves to RUN.
REQ-015 In RUN, each cycle: the slice adds nibble[cnt] of the captured a and b with the carry register; the result nibble is written to sum[4*cnt+:4]; the slice carry-out is written to the carry register; cnt increments.
REQ-016 Slice: per bit g=a&b, p=a^b; c1..c4 by lookahead equations; s=p^c. No ripple between slice bits.
REQ-017 When cnt==NIB-1 in RUN, the FSM SHALL go to DONE on the next edge; cout SHALL take the final carry; cnt SHALL wrap to 0.
REQ-018 Latency: operands accepted at edge k SHALL give out_valid=1 after edge k+NIB. For WIDTH=16 this is 4 cycles.
REQ-019 In DONE: out_valid=1; sum, cout and ovf SHALL be held stable until out_ready=1, then the FSM returns to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored and no operands are captured.
REQ-021 If DONE with out_ready=1 and in_valid=1 occur together, the new operands SHALL NOT be accepted; they are accepted in the following IDLE cycle. Maximum throughput is one op per NIB+2 cycles.
REQ-022 sum bits not yet written in RUN SHALL hold their previous values. out_valid=0 marks them as don't-care.

Reset
REQ-023 When rst_n=0 at a rising edge: state=IDLE, cnt=0, carry=0, sum=0, cout=0, ovf=0 and out_valid=0.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse. in_ready=1 on the first cycle after rst_n returns to 1.
REQ-025 in_ready SHALL be driven 0 while rst_n=0.

Configuration
REQ-026 Macro CLA_SEQ_OVF_EN defined: port ovf exists, and ovf = carry into the MSB XOR cout, registered at the last RUN cycle and held in DONE.
REQ-027 CLA_SEQ_OVF_EN undefined: no ovf port and no ovf logic; all other behaviour is identical.

Structure
REQ-028 A shared package/header SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant 4.
REQ-029 The 4-bit lookahead slice SHALL be one sub-module, cla4_slice (inputs a[3:0], b[3:0], ci; outputs s[3:0], co, c3), using per-bit generate/propagate cells. It SHALL be instantiated exactly once.

Verification
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-031 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 for exactly 5 cycles after acceptance when out_ready is tied to 1.
REQ-032 a=0x7FFF, b=0x0001, cin=0 with CLA_SEQ_OVF_EN defined -> sum=0x8000, cout=0, ovf=1.
REQ-033 out_ready=0 for 10 cycles in DONE -> out_valid, sum and cout stay constant. A second in_valid pulse during this time is ignored, and its result never appears.
REQ-034 rst_n=0 for 1 cycle at RUN cnt=2 -> no out_valid; in_ready=1 the next cycle; a new op a=0x0003, b=0x0004 gives sum=0x0007.
REQ-035 Randomised back-to-back ops (≥1000) with random out_ready -> every result matches the reference a+b+cin, and no op is lost or duplicated.

Source files
------------

// File: rtl/cla_add_sequencer_pkg.sv
// Shared constants for the sequential CLA adder: FSM state
// encodings and the width of the lookahead slice.
package cla_add_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cla_add_sequencer_slice.sv
// cla4_slice: 4-bit carry-lookahead adder slice.
// Ports: a,b[3:0], ci in; s[3:0], co (carry out), c3 (carry into bit 3).
module cla4_slice
  import cla_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c3
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_gp
    assign g[i] = a[i] & b[i];
    assign p[i] = a[i] ^ b[i];
  end

  // Every carry is a flat function of g, p and ci; no bit waits on another.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/cla_add_sequencer.sv
// Sequential adder: {cout,sum} = a + b + cin, one nibble per cycle
// through a single cla4_slice, LSB nibble first. Handshake on
// in_valid/in_ready and out_valid/out_ready; sync active-low rst_n.
// Ports: clk, rst_n, in_valid, in_ready, a, b, cin,
//        out_valid, out_ready, sum, cout, ovf (CLA_SEQ_OVF_EN only).
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  seq_state_t      state;
  logic [CW-1:0]   cnt;
  logic [CW+1:0]   base;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SLICE_W-1:0] s_n;
  logic            co_n;
  logic            c3_n;

  assign base = {cnt, 2'b00};

  cla4_slice u_slice (
    .a  (a_q[base +: SLICE_W]),
    .b  (b_q[base +: SLICE_W]),
    .ci (carry),
    .s  (s_n),
    .co (co_n),
    .c3 (c3_n)
  );

  assign in_ready = rst_n & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: SLICE_W] <= s_n;
          carry <= co_n;
          if (cnt == LAST) begin
            cnt       <= '0;
            cout      <= co_n;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= c3_n ^ co_n;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CLA_SEQ_OVF_EN
  // Carry into the MSB only feeds overflow detection.
  logic unused_c3;
  assign unused_c3 = c3_n;
`endif

endmodule
